// File: rtl/sram_bist_pkg.sv
// Shared types, default sizing and the test-pattern function for the SRAM BIST controller.
package sram_bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_SETUP,
        WR_STROBE,
        RD,
        DONE
    } bistStateT;

    localparam int          DEPTH_DEF     = 128;
    localparam int          ADDR_BITS_DEF = 7;
    localparam int          WORD_BITS_DEF = 8;
    localparam logic [7:0]  SEED_DEF      = 8'hA5;

    // Zero-extended address XOR seed, optionally inverted; caller truncates to its word width.
    function automatic logic [31:0] expected(input logic [31:0] addr,
                                             input logic        invert,
                                             input logic [31:0] seed);
        logic [31:0] p;
        p = addr ^ seed;
        return invert ? ~p : p;
    endfunction

endpackage

// File: rtl/sram_bist_if.sv
// SRAM port bundle: the BIST drives addresses/write strobe (master), the SRAM returns read data (slave).
interface sram_bist_if #(
    parameter int ADDR_BITS = 7,
    parameter int WORD_BITS = 8
);
    logic [ADDR_BITS-1:0] rd_addr;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [WORD_BITS-1:0] wr_data;
    logic [WORD_BITS-1:0] rd_data;
    logic                 wr_en;

    modport master (
        output rd_addr, wr_addr, wr_data, wr_en,
        input  rd_data
    );

    modport slave (
        input  rd_addr, wr_addr, wr_data, wr_en,
        output rd_data
    );
endinterface

// File: rtl/sram_bist_checker.sv
// Read-back scoreboard: saturating mismatch counter plus capture of the first failing address.
module sram_bist_checker #(
    parameter int ADDR_BITS = 7,
    parameter int CNT_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 valid,
    input  logic                 match,
    input  logic [ADDR_BITS-1:0] addr,
    output logic [CNT_BITS-1:0]  failCount,
    output logic [ADDR_BITS-1:0] firstFailAddr
);

    logic [CNT_BITS-1:0]  countReg;
    logic [ADDR_BITS-1:0] firstReg;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            countReg <= '0;
            firstReg <= '0;
        end else if (valid && !match) begin
            if (countReg != '1) begin
                countReg <= countReg + CNT_BITS'(1);
            end
            if (countReg == '0) begin
                firstReg <= addr;
            end
        end
    end

    assign failCount     = countReg;
    assign firstFailAddr = firstReg;

endmodule

// File: rtl/sram_bist.sv
// BIST initiator for the 128x8 register-file SRAM: pattern write sweep, then read-back compare.
// Build option SRAM_BIST_INVERT_PASS_EN adds a second sweep using the inverted pattern.
module sram_bist
    import sram_bist_pkg::*;
#(
    parameter int                   DEPTH     = DEPTH_DEF,
    parameter int                   ADDR_BITS = ADDR_BITS_DEF,
    parameter int                   WORD_BITS = WORD_BITS_DEF,
    parameter logic [WORD_BITS-1:0] SEED      = WORD_BITS'(SEED_DEF),
    localparam int                  CNT_BITS  = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    sram_bist_if.master          sram,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CNT_BITS-1:0]  fail_count,
    output logic [ADDR_BITS-1:0] first_fail_addr
);

    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);

    function automatic logic [WORD_BITS-1:0] patternOf(input logic [ADDR_BITS-1:0] a,
                                                       input logic                 inv);
        return WORD_BITS'(expected(32'(a), inv, 32'(SEED)));
    endfunction

    bistStateT            stateReg;
    logic [ADDR_BITS-1:0] addrReg;
    logic [ADDR_BITS-1:0] addrNext;
    logic [ADDR_BITS-1:0] rdAddrReg;
    logic [ADDR_BITS-1:0] wrAddrReg;
    logic [WORD_BITS-1:0] wrDataReg;
    logic                 wrEnReg;
    logic                 busyReg;
    logic                 doneReg;
    logic                 passReg;
    logic                 phaseReg;
    logic                 lastSweep;
    logic                 startAccept;
    logic                 rdMatch;
    logic [CNT_BITS-1:0]  failCount;

    assign addrNext    = addrReg + ADDR_BITS'(1);
    assign startAccept = (stateReg == IDLE) && start;
    // Read is combinational, so compare this cycle's rd_data against the registered address.
    assign rdMatch     = (sram.rd_data == patternOf(rdAddrReg, phaseReg));

`ifdef SRAM_BIST_INVERT_PASS_EN
    // Phase 0 sweeps the true pattern, phase 1 the inverted one.
    always_ff @(posedge clk) begin
        if (reset || startAccept) begin
            phaseReg <= 1'b0;
        end else if (stateReg == RD && addrReg == LAST_ADDR) begin
            phaseReg <= 1'b1;
        end
    end
    assign lastSweep = phaseReg;
`else
    assign phaseReg  = 1'b0;
    assign lastSweep = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg  <= IDLE;
            addrReg   <= '0;
            rdAddrReg <= '0;
            wrAddrReg <= '0;
            wrDataReg <= '0;
            wrEnReg   <= 1'b0;
            busyReg   <= 1'b0;
            doneReg   <= 1'b0;
            passReg   <= 1'b0;
        end else begin
            doneReg <= 1'b0;
            unique case (stateReg)
                IDLE: begin
                    if (start) begin
                        stateReg  <= WR_SETUP;
                        addrReg   <= '0;
                        wrAddrReg <= '0;
                        wrDataReg <= patternOf('0, 1'b0);
                        busyReg   <= 1'b1;
                        passReg   <= 1'b0;
                    end
                end
                WR_SETUP: begin
                    wrEnReg  <= 1'b1;
                    stateReg <= WR_STROBE;
                end
                WR_STROBE: begin
                    // Address/data only move while the strobe is dropping, never under it.
                    wrEnReg <= 1'b0;
                    if (addrReg == LAST_ADDR) begin
                        stateReg  <= RD;
                        addrReg   <= '0;
                        rdAddrReg <= '0;
                    end else begin
                        stateReg  <= WR_SETUP;
                        addrReg   <= addrNext;
                        wrAddrReg <= addrNext;
                        wrDataReg <= patternOf(addrNext, phaseReg);
                    end
                end
                RD: begin
                    if (addrReg == LAST_ADDR) begin
                        addrReg <= '0;
                        if (lastSweep) begin
                            stateReg <= DONE;
                            doneReg  <= 1'b1;
                            busyReg  <= 1'b0;
                            passReg  <= (failCount == '0) && rdMatch;
                        end else begin
                            stateReg  <= WR_SETUP;
                            wrAddrReg <= '0;
                            wrDataReg <= patternOf('0, 1'b1);
                        end
                    end else begin
                        addrReg   <= addrNext;
                        rdAddrReg <= addrNext;
                    end
                end
                DONE: begin
                    stateReg <= IDLE;
                end
                default: begin
                    stateReg <= IDLE;
                end
            endcase
        end
    end

    sram_bist_checker #(
        .ADDR_BITS (ADDR_BITS),
        .CNT_BITS  (CNT_BITS)
    ) u_checker (
        .clk           (clk),
        .reset         (reset),
        .clear         (startAccept),
        .valid         (stateReg == RD),
        .match         (rdMatch),
        .addr          (rdAddrReg),
        .failCount     (failCount),
        .firstFailAddr (first_fail_addr)
    );

    assign sram.rd_addr = rdAddrReg;
    assign sram.wr_addr = wrAddrReg;
    assign sram.wr_data = wrDataReg;
    assign sram.wr_en   = wrEnReg;
    assign busy         = busyReg;
    assign done         = doneReg;
    assign pass         = passReg;
    assign fail_count   = failCount;

endmodule

// File: tb/tb_sram_bist.sv
// Bench for sram_bist: faultable SRAM model, reference scoreboard, write-strobe protocol monitor.
// Honours SRAM_BIST_INVERT_PASS_EN to expect the two-sweep variant.
module tb_sram_bist;

    localparam int DEPTH   = 128;
    localparam int AB      = 7;
    localparam int WB      = 8;
    localparam int CNT_MAX = 255;
`ifdef SRAM_BIST_INVERT_PASS_EN
    localparam int SWEEPS = 2;
`else
    localparam int SWEEPS = 1;
`endif
    localparam int RUN_EDGES = 3 * DEPTH * SWEEPS;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          busy;
    logic          done;
    logic          pass;
    logic [7:0]    fail_count;
    logic [AB-1:0] first_fail_addr;

    sram_bist_if #(.ADDR_BITS(AB), .WORD_BITS(WB)) bus ();

    sram_bist #(
        .DEPTH     (DEPTH),
        .ADDR_BITS (AB),
        .WORD_BITS (WB),
        .SEED      (8'hA5)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .sram            (bus),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .fail_count      (fail_count),
        .first_fail_addr (first_fail_addr)
    );

    always #5 clk = ~clk;

    int checks    = 0;
    int errors    = 0;
    int protoViol = 0;
    int faultMode = 0;  // 0 none, 1 single stuck bit at one address, 2 every read returns zero
    int faultAddr = 0;
    int faultBit  = 0;
    int faultVal  = 0;

    logic [7:0] mem [DEPTH];

    function automatic logic [7:0] faultRead(input int mode, input int fa, input int fb,
                                             input int fv, input int a, input logic [7:0] v);
        logic [7:0] m;
        m = 8'(1 << fb);
        if (mode == 2) return 8'h00;
        if (mode == 1 && a == fa) return (fv != 0) ? (v | m) : (v & ~m);
        return v;
    endfunction

    always @(posedge clk) begin
        if (bus.wr_en === 1'b1) mem[bus.wr_addr] <= bus.wr_data;
    end

    always_comb bus.rd_data = faultRead(faultMode, faultAddr, faultBit, faultVal,
                                        int'(bus.rd_addr), mem[bus.rd_addr]);

    logic [AB-1:0] prevWa;
    logic [WB-1:0] prevWd;
    always begin
        @(posedge clk);
        #1;
        if (bus.wr_en === 1'b1 && (bus.wr_addr !== prevWa || bus.wr_data !== prevWd)) protoViol++;
        prevWa = bus.wr_addr;
        prevWd = bus.wr_data;
    end

    function automatic int patternAt(input int a, input int sweep);
        return ((a ^ 'hA5) ^ ((sweep != 0) ? 'hFF : 0)) & 'hFF;
    endfunction

    // What a correct BIST must report for a given SRAM fault, sweep by sweep.
    function automatic void refModel(input int mode, input int fa, input int fb, input int fv,
                                     output int cnt, output int first);
        int seen;
        cnt   = 0;
        first = 0;
        for (int s = 0; s < SWEEPS; s++) begin
            for (int a = 0; a < DEPTH; a++) begin
                seen = int'(faultRead(mode, fa, fb, fv, a, 8'(patternAt(a, s))));
                if (seen != patternAt(a, s)) begin
                    if (cnt == 0) first = a;
                    if (cnt < CNT_MAX) cnt++;
                end
            end
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic runTest(input string tag, input int mode, input int fa, input int fb,
                           input int fv, input bit repulse);
        int doneK, busyN, expCnt, expFirst, viol0, extra, bad;
        faultMode = mode;
        faultAddr = fa;
        faultBit  = fb;
        faultVal  = fv;
        refModel(mode, fa, fb, fv, expCnt, expFirst);
        repeat ($urandom_range(0, 4)) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        viol0 = protoViol;
        @(posedge clk);
        #1;
        start = 1'b0;
        doneK = -1;
        busyN = 0;
        for (int k = 0; k <= RUN_EDGES + 20; k++) begin
            if (busy === 1'b1) busyN++;
            if (done === 1'b1) begin
                doneK = k;
                break;
            end
            start = (repulse && k == 49) ? 1'b1 : 1'b0;
            @(posedge clk);
            #1;
        end
        check({tag, ".done_cycle"}, 32'(doneK + 1), 32'(RUN_EDGES + 1));
        check({tag, ".busy_cycles"}, 32'(busyN), 32'(RUN_EDGES));
        check({tag, ".fail_count"}, 32'(fail_count), 32'(expCnt));
        check({tag, ".first_fail"}, 32'(first_fail_addr), 32'(expFirst));
        check({tag, ".pass"}, 32'(pass), 32'(expCnt == 0));
        start = repulse;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, ".done_pulse"}, 32'(done), 32'(0));
        extra = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (busy !== 1'b0 || done !== 1'b0) extra++;
        end
        check({tag, ".no_restart"}, 32'(extra), 32'(0));
        check({tag, ".hold_count"}, 32'(fail_count), 32'(expCnt));
        check({tag, ".hold_pass"}, 32'(pass), 32'(expCnt == 0));
        check({tag, ".protocol"}, 32'(protoViol - viol0), 32'(0));
        bad = 0;
        for (int a = 0; a < DEPTH; a++) begin
            if (int'(mem[a]) != patternAt(a, SWEEPS - 1)) bad++;
        end
        check({tag, ".mem_image"}, 32'(bad), 32'(0));
        $display("run %s: mode=%0d addr=%0d bit=%0d val=%0d done_cycle=%0d fail_count=%0d first=%0d pass=%0d",
                 tag, mode, fa, fb, fv, doneK + 1, fail_count, first_fail_addr, pass);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.busy", 32'(busy), 32'(0));
        check("reset.done", 32'(done), 32'(0));
        check("reset.pass", 32'(pass), 32'(0));
        check("reset.fail_count", 32'(fail_count), 32'(0));
        check("reset.first_fail", 32'(first_fail_addr), 32'(0));
        check("reset.wr_en", 32'(bus.wr_en), 32'(0));
        @(negedge clk);
        reset = 1'b0;

        runTest("clean", 0, 0, 0, 0, 1'b0);
        runTest("sa0_addr5", 1, 5, 3, 0, 1'b0);
        runTest("sa0_addr8", 1, 8, 3, 0, 1'b0);
        runTest("all_zero", 2, 0, 0, 0, 1'b0);
        runTest("repulse", 0, 0, 0, 0, 1'b1);

        // Reset landing mid-write, while the strobe is high.
        faultMode = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (99) @(posedge clk);
        #1;
        check("midreset.wr_en_before", 32'(bus.wr_en), 32'(1));
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midreset.wr_en", 32'(bus.wr_en), 32'(0));
        check("midreset.busy", 32'(busy), 32'(0));
        check("midreset.fail_count", 32'(fail_count), 32'(0));
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("midreset.idle", 32'(busy), 32'(0));
        $display("run midreset: busy=%0d wr_en=%0d", busy, bus.wr_en);
        runTest("after_reset", 0, 0, 0, 0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            runTest($sformatf("rnd%0d", i), int'($urandom_range(0, 2)),
                    int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
